axi_slave_ram: RTL and testbench
================================

AXI_SLAVE_RAM -- requirements
Module: axi_slave_ram

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 4: width of all ID fields, equal to the slave-side ID width of the bus.
REQ-002 SHALL have parameter MEM_AW, default 10: log2 of the memory depth in 32-bit words.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h00000000: address window base, subtracted before indexing.
REQ-004 BUS_CLK  in  1  single clock; all logic on the rising edge.
REQ-005 BUS_RST  in  1  reset, synchronous and active-high.
REQ-006 AW channel, write address: S_AWID in ID_WIDTH; S_AWADDR in 32; S_AWLEN in 8; S_AWBURST in 2; S_AWVALID in 1; S_AWREADY out 1.
REQ-007 W channel, write data: S_WDATA in 32; S_WSTRB in 4; S_WLAST in 1; S_WVALID in 1; S_WREADY out 1.
REQ-008 B channel, write response: S_BID out ID_WIDTH; S_BRESP out 2; S_BVALID out 1; S_BREADY in 1.
REQ-009 AR channel, read address: S_ARID in ID_WIDTH; S_ARADDR in 32; S_ARLEN in 8; S_ARBURST in 2; S_ARVALID in 1; S_ARREADY out 1.
REQ-010 R channel, read data: S_RID out ID_WIDTH; S_RDATA out 32; S_RRESP out 2; S_RLAST out 1; S_RVALID out 1; S_RREADY in 1.

Function
REQ-011 Memory: 2**MEM_AW x 32-bit words. Word index = (addr - BASE_ADDR)[MEM_AW+1:2]. Higher offset bits are ignored, so accesses alias. addr[1:0] is ignored.
REQ-012 Write FSM and read FSM SHALL be independent and may run concurrently. Each accepts one burst at a time, in order. No interleaving.
REQ-013 Write FSM states:
- W_IDLE: AWREADY=1. On AW handshake, latch ID, addr, LEN and BURST, then go to W_DATA.
- W_DATA: WREADY=1. Each W handshake writes the bytes enabled by WSTRB, then advances the address.
- W_DATA exit: the WLAST handshake goes to W_RESP.
- W_RESP: BVALID=1 with BID = latched ID. On BREADY, go to W_IDLE.
REQ-014 Address advance:
- FIXED (00): address does not change.
- INCR (01): address +4 per beat.
- WRAP (10): address +4 per beat, wrapping at the aligned (LEN+1)*4 byte boundary.
REQ-015 Illegal burst: BURST=11, or WRAP with LEN not in {1,3,7,15}. Memory writes for the burst SHALL be suppressed and BRESP=SLVERR (2'b10). Otherwise BRESP=OKAY (00).
REQ-016 WLAST mismatch: WLAST on a beat other than beat LEN, or beats beyond LEN without WLAST. The FSM SHALL leave W_DATA only on the WLAST handshake. Beats beyond LEN SHALL be dropped. BRESP=SLVERR.
REQ-017 Read FSM states:
- R_IDLE: ARREADY=1. On AR handshake, latch ID, addr, LEN and BURST, then go to R_DATA.
- R_DATA: RVALID=1. RDATA = word at the current address and RID = latched ID.
- R_DATA beats: on each R handshake the address advances per REQ-014 and the beat counter increments.
- R_DATA exit: on the handshake of beat LEN (RLAST=1), go to R_IDLE.
REQ-018 Read timing:
- First RVALID is asserted the cycle after the AR handshake.
- With RREADY held high, one beat per cycle.
- Throughout an illegal read burst, RRESP=SLVERR and RDATA=0.
REQ-019 RLAST=1 only on beat LEN. For LEN=0, the single beat has RLAST=1.
REQ-020 While VALID=1 and READY=0, RVALID/RDATA/RID/RLAST/RRESP and BVALID/BID/BRESP SHALL hold stable.
REQ-021 Same-cycle read of a word being written SHALL return the pre-write value. The write is visible from the next cycle.
REQ-022 Beat counter is 8 bits, which covers the 256-beat maximum.

Reset
REQ-023 While BUS_RST=1, all READY and VALID outputs SHALL be 0. BID, BRESP, RID, RDATA, RRESP and RLAST SHALL be 0.
REQ-024 While BUS_RST=1, both FSMs SHALL return to idle and any in-flight burst SHALL be abandoned with no response issued. Memory contents are not cleared.
REQ-025 First cycle after BUS_RST deasserts: AWREADY=1 and ARREADY=1.

Verification
REQ-026 Single write, then read: AW addr=0x10, LEN=0, INCR, ID=3; W data=0xDEADBEEF, STRB=F -> BRESP=00, BID=3. AR addr=0x10, LEN=0 -> RDATA=0xDEADBEEF, RLAST=1, RID=3.
REQ-027 INCR, WSTRB and backpressure: INCR LEN=3 at 0x0 writing 1,2,3,4, then STRB=0001 writing 0xFFFFFFFF to 0x4. Read LEN=3 with RREADY toggling each cycle -> data 1, 0x000000FF, 3, 4; outputs stable while stalled; RLAST on beat 3 only.
REQ-028 WRAP: WRAP LEN=3 at 0x38 writing A,B,C,D -> mem[0x38]=A, 0x3C=B, 0x30=C, 0x34=D.
REQ-029 Error cases:
- BURST=11 write -> memory unchanged, BRESP=10.
- WRAP LEN=2 read -> 3 beats, RRESP=10, RDATA=0.
- WLAST on beat 1 of a LEN=3 burst -> BRESP=10.
REQ-030 Concurrency and reset:
- Read and write to different addresses overlap -> both complete correctly.
- BUS_RST asserted mid R_DATA -> RVALID=0 the next cycle, ARREADY=1 after release.

Source files
------------

// File: rtl/axi_slave_ram_if.sv
// AXI4 slave-side bus bundle for axi_slave_ram: AW, W, B, AR and R channels.
// The master modport is the bus driver (testbench or interconnect).
interface axi_slave_ram_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] S_AWID;
    logic [31:0]         S_AWADDR;
    logic [7:0]          S_AWLEN;
    logic [1:0]          S_AWBURST;
    logic                S_AWVALID;
    logic                S_AWREADY;

    logic [31:0]         S_WDATA;
    logic [3:0]          S_WSTRB;
    logic                S_WLAST;
    logic                S_WVALID;
    logic                S_WREADY;

    logic [ID_WIDTH-1:0] S_BID;
    logic [1:0]          S_BRESP;
    logic                S_BVALID;
    logic                S_BREADY;

    logic [ID_WIDTH-1:0] S_ARID;
    logic [31:0]         S_ARADDR;
    logic [7:0]          S_ARLEN;
    logic [1:0]          S_ARBURST;
    logic                S_ARVALID;
    logic                S_ARREADY;

    logic [ID_WIDTH-1:0] S_RID;
    logic [31:0]         S_RDATA;
    logic [1:0]          S_RRESP;
    logic                S_RLAST;
    logic                S_RVALID;
    logic                S_RREADY;

    modport slave (
        input  S_AWID, S_AWADDR, S_AWLEN, S_AWBURST, S_AWVALID,
        output S_AWREADY,
        input  S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
        output S_WREADY,
        output S_BID, S_BRESP, S_BVALID,
        input  S_BREADY,
        input  S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID,
        output S_ARREADY,
        output S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        input  S_RREADY
    );

    modport master (
        output S_AWID, S_AWADDR, S_AWLEN, S_AWBURST, S_AWVALID,
        input  S_AWREADY,
        output S_WDATA, S_WSTRB, S_WLAST, S_WVALID,
        input  S_WREADY,
        input  S_BID, S_BRESP, S_BVALID,
        output S_BREADY,
        output S_ARID, S_ARADDR, S_ARLEN, S_ARBURST, S_ARVALID,
        input  S_ARREADY,
        input  S_RID, S_RDATA, S_RRESP, S_RLAST, S_RVALID,
        output S_RREADY
    );
endinterface

// File: rtl/axi_slave_ram.sv
// AXI4 burst slave backed by a 2**MEM_AW x 32-bit RAM with byte strobes.
// Independent write and read FSMs; FIXED/INCR/WRAP bursts, SLVERR on illegal bursts.
module axi_slave_ram #(
    parameter int          ID_WIDTH  = 4,
    parameter int          MEM_AW    = 10,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic          BUS_CLK,
    input logic          BUS_RST,
    axi_slave_ram_if.slave bus
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                              input logic [1:0] burst);
        logic [31:0] mask;
        mask = (({24'd0, len} + 32'd1) << 2) - 32'd1;
        case (burst)
            2'b00:   return a;
            2'b10:   return (a & ~mask) | ((a + 32'd4) & mask);
            default: return a + 32'd4;
        endcase
    endfunction

    function automatic logic illegal_burst(input logic [7:0] len, input logic [1:0] burst);
        return (burst == 2'b11) ||
               ((burst == 2'b10) && !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15));
    endfunction

    function automatic logic [MEM_AW-1:0] word_idx(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE_ADDR;
        return off[MEM_AW+1:2];
    endfunction

    logic [31:0] mem [2**MEM_AW];

    w_state_t            w_state, w_next;
    logic [ID_WIDTH-1:0] w_id;
    logic [31:0]         w_addr;
    logic [7:0]          w_len, w_cnt;
    logic [1:0]          w_burst;
    logic                w_over, w_err;
    logic                aw_ready, w_ready, b_valid, aw_hs, w_hs, b_hs, mem_we;

    assign aw_ready = (w_state == W_IDLE) && !BUS_RST;
    assign w_ready  = (w_state == W_DATA) && !BUS_RST;
    assign b_valid  = (w_state == W_RESP) && !BUS_RST;
    assign aw_hs    = bus.S_AWVALID && aw_ready;
    assign w_hs     = bus.S_WVALID && w_ready;
    assign b_hs     = bus.S_BREADY && b_valid;
    assign mem_we   = w_hs && !w_over && !w_err;

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) w_state <= W_IDLE;
        else         w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE:  if (aw_hs) w_next = W_DATA;
            W_DATA:  if (w_hs && bus.S_WLAST) w_next = W_RESP;
            W_RESP:  if (b_hs) w_next = W_IDLE;
            default: w_next = W_IDLE;
        endcase
    end

    // w_over marks that beat LEN has been taken; later beats are dropped until WLAST.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_burst <= '0;
            w_cnt   <= '0;
            w_over  <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            if (aw_hs) begin
                w_id    <= bus.S_AWID;
                w_addr  <= bus.S_AWADDR;
                w_len   <= bus.S_AWLEN;
                w_burst <= bus.S_AWBURST;
                w_cnt   <= '0;
                w_over  <= 1'b0;
                w_err   <= illegal_burst(bus.S_AWLEN, bus.S_AWBURST);
            end
            if (w_hs) begin
                if (!w_over) begin
                    w_addr <= next_addr(w_addr, w_len, w_burst);
                    w_cnt  <= w_cnt + 8'd1;
                    if (w_cnt == w_len) w_over <= 1'b1;
                end
                if (bus.S_WLAST ? (w_over || (w_cnt != w_len)) : (w_over || (w_cnt == w_len)))
                    w_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (bus.S_WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= bus.S_WDATA[8*b +: 8];
            end
        end
    end

    assign bus.S_AWREADY = aw_ready;
    assign bus.S_WREADY  = w_ready;
    assign bus.S_BVALID  = b_valid;
    assign bus.S_BID     = b_valid ? w_id : '0;
    assign bus.S_BRESP   = (b_valid && w_err) ? RESP_SLVERR : RESP_OKAY;

    r_state_t            r_state, r_next;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_addr, r_nxt, r_data;
    logic [7:0]          r_len, r_cnt;
    logic [1:0]          r_burst;
    logic                r_err, ar_ready, r_valid, ar_hs, r_hs, r_last;

    assign ar_ready = (r_state == R_IDLE) && !BUS_RST;
    assign r_valid  = (r_state == R_DATA) && !BUS_RST;
    assign ar_hs    = bus.S_ARVALID && ar_ready;
    assign r_hs     = bus.S_RREADY && r_valid;
    assign r_last   = r_valid && (r_cnt == r_len);
    assign r_nxt    = next_addr(r_addr, r_len, r_burst);

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) r_state <= R_IDLE;
        else         r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_next = R_DATA;
            R_DATA:  if (r_hs && r_last) r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Read data is registered so it stays stable under backpressure even if the word is rewritten.
    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            r_id    <= '0;
            r_addr  <= '0;
            r_len   <= '0;
            r_burst <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_data  <= '0;
        end else begin
            if (ar_hs) begin
                r_id    <= bus.S_ARID;
                r_addr  <= bus.S_ARADDR;
                r_len   <= bus.S_ARLEN;
                r_burst <= bus.S_ARBURST;
                r_cnt   <= '0;
                r_err   <= illegal_burst(bus.S_ARLEN, bus.S_ARBURST);
                r_data  <= illegal_burst(bus.S_ARLEN, bus.S_ARBURST) ? 32'd0
                                                                     : mem[word_idx(bus.S_ARADDR)];
            end else if (r_hs && !r_last) begin
                r_addr <= r_nxt;
                r_cnt  <= r_cnt + 8'd1;
                r_data <= r_err ? 32'd0 : mem[word_idx(r_nxt)];
            end
        end
    end

    assign bus.S_ARREADY = ar_ready;
    assign bus.S_RVALID  = r_valid;
    assign bus.S_RDATA   = r_valid ? r_data : 32'd0;
    assign bus.S_RID     = r_valid ? r_id : '0;
    assign bus.S_RRESP   = (r_valid && r_err) ? RESP_SLVERR : RESP_OKAY;
    assign bus.S_RLAST   = r_last;
endmodule

// File: tb/tb_axi_slave_ram.sv
// Directed bench for axi_slave_ram: single/burst writes and reads, strobes, WRAP,
// error responses, backpressure, concurrent channels and mid-burst reset.
module tb_axi_slave_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    axi_slave_ram_if #(.ID_WIDTH(4)) ifc ();

    axi_slave_ram #(.ID_WIDTH(4), .MEM_AW(10), .BASE_ADDR(32'h0)) dut (
        .BUS_CLK(clk),
        .BUS_RST(rst),
        .bus    (ifc.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic aw_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        ifc.S_AWADDR = addr; ifc.S_AWLEN = len; ifc.S_AWBURST = burst; ifc.S_AWID = id;
        ifc.S_AWVALID = 1'b1;
        while (!ifc.S_AWREADY && n < 20) begin @(negedge clk); n++; end
        chk("aw_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        ifc.S_AWVALID = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n = 0;
        ifc.S_WDATA = data; ifc.S_WSTRB = strb; ifc.S_WLAST = last; ifc.S_WVALID = 1'b1;
        while (!ifc.S_WREADY && n < 20) begin @(negedge clk); n++; end
        chk("w_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        ifc.S_WVALID = 1'b0;
    endtask

    task automatic b_recv(input logic [1:0] resp, input logic [3:0] id);
        int n = 0;
        ifc.S_BREADY = 1'b1;
        while (!ifc.S_BVALID && n < 20) begin @(negedge clk); n++; end
        chk("b_timeout", 32'(n < 20), 32'd1);
        chk("bresp", 32'(ifc.S_BRESP), 32'(resp));
        chk("bid", 32'(ifc.S_BID), 32'(id));
        @(negedge clk);
        ifc.S_BREADY = 1'b0;
    endtask

    task automatic ar_send(input logic [31:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        ifc.S_ARADDR = addr; ifc.S_ARLEN = len; ifc.S_ARBURST = burst; ifc.S_ARID = id;
        ifc.S_ARVALID = 1'b1;
        while (!ifc.S_ARREADY && n < 20) begin @(negedge clk); n++; end
        chk("ar_timeout", 32'(n < 20), 32'd1);
        @(negedge clk);
        ifc.S_ARVALID = 1'b0;
        chk("rvalid_after_ar", 32'(ifc.S_RVALID), 32'd1);
    endtask

    task automatic r_recv(input logic [31:0] data, input logic last,
                          input logic [1:0] resp, input logic [3:0] id);
        int n = 0;
        ifc.S_RREADY = 1'b1;
        while (!ifc.S_RVALID && n < 20) begin @(negedge clk); n++; end
        chk("r_timeout", 32'(n < 20), 32'd1);
        chk("rdata", ifc.S_RDATA, data);
        chk("rlast", 32'(ifc.S_RLAST), 32'(last));
        chk("rresp", 32'(ifc.S_RRESP), 32'(resp));
        chk("rid", 32'(ifc.S_RID), 32'(id));
        @(negedge clk);
        ifc.S_RREADY = 1'b0;
    endtask

    logic [31:0] exp_bp [4];
    logic [31:0] held;

    initial begin
        ifc.S_AWID = '0; ifc.S_AWADDR = '0; ifc.S_AWLEN = '0; ifc.S_AWBURST = '0; ifc.S_AWVALID = 0;
        ifc.S_WDATA = '0; ifc.S_WSTRB = '0; ifc.S_WLAST = 0; ifc.S_WVALID = 0; ifc.S_BREADY = 0;
        ifc.S_ARID = '0; ifc.S_ARADDR = '0; ifc.S_ARLEN = '0; ifc.S_ARBURST = '0; ifc.S_ARVALID = 0;
        ifc.S_RREADY = 0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_awready", 32'(ifc.S_AWREADY), 32'd0);
        chk("rst_arready", 32'(ifc.S_ARREADY), 32'd0);
        chk("rst_wready", 32'(ifc.S_WREADY), 32'd0);
        chk("rst_bvalid", 32'(ifc.S_BVALID), 32'd0);
        chk("rst_rvalid", 32'(ifc.S_RVALID), 32'd0);
        chk("rst_rdata", ifc.S_RDATA, 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_awready", 32'(ifc.S_AWREADY), 32'd1);
        chk("post_rst_arready", 32'(ifc.S_ARREADY), 32'd1);
        @(negedge clk);

        // Single write then read
        aw_send(32'h10, 8'd0, 2'b01, 4'd3);
        w_send(32'hDEADBEEF, 4'hF, 1'b1);
        b_recv(2'b00, 4'd3);
        ar_send(32'h10, 8'd0, 2'b01, 4'd3);
        r_recv(32'hDEADBEEF, 1'b1, 2'b00, 4'd3);
        chk("rvalid_done", 32'(ifc.S_RVALID), 32'd0);

        // INCR burst plus byte-strobe overwrite
        aw_send(32'h0, 8'd3, 2'b01, 4'd1);
        w_send(32'd1, 4'hF, 1'b0);
        w_send(32'd2, 4'hF, 1'b0);
        w_send(32'd3, 4'hF, 1'b0);
        w_send(32'd4, 4'hF, 1'b1);
        b_recv(2'b00, 4'd1);
        aw_send(32'h4, 8'd0, 2'b01, 4'd2);
        w_send(32'hFFFFFFFF, 4'b0001, 1'b1);
        b_recv(2'b00, 4'd2);

        // Read back with RREADY toggling every cycle
        exp_bp[0] = 32'd1; exp_bp[1] = 32'h000000FF; exp_bp[2] = 32'd3; exp_bp[3] = 32'd4;
        ar_send(32'h0, 8'd3, 2'b01, 4'd5);
        for (int i = 0; i < 4; i++) begin
            ifc.S_RREADY = 1'b0;
            chk("bp_rvalid", 32'(ifc.S_RVALID), 32'd1);
            chk("bp_rdata", ifc.S_RDATA, exp_bp[i]);
            held = ifc.S_RDATA;
            @(negedge clk);
            chk("bp_rdata_stable", ifc.S_RDATA, held);
            chk("bp_rvalid_stable", 32'(ifc.S_RVALID), 32'd1);
            chk("bp_rlast", 32'(ifc.S_RLAST), 32'(i == 3));
            chk("bp_rid", 32'(ifc.S_RID), 32'd5);
            ifc.S_RREADY = 1'b1;
            @(negedge clk);
        end
        ifc.S_RREADY = 1'b0;
        chk("bp_rvalid_end", 32'(ifc.S_RVALID), 32'd0);

        // WRAP write at 0x38: lands at 38,3C,30,34
        aw_send(32'h38, 8'd3, 2'b10, 4'd4);
        w_send(32'hA, 4'hF, 1'b0);
        w_send(32'hB, 4'hF, 1'b0);
        w_send(32'hC, 4'hF, 1'b0);
        w_send(32'hD, 4'hF, 1'b1);
        b_recv(2'b00, 4'd4);
        ar_send(32'h30, 8'd3, 2'b01, 4'd4);
        r_recv(32'hC, 1'b0, 2'b00, 4'd4);
        r_recv(32'hD, 1'b0, 2'b00, 4'd4);
        r_recv(32'hA, 1'b0, 2'b00, 4'd4);
        r_recv(32'hB, 1'b1, 2'b00, 4'd4);

        // Illegal burst type: write suppressed, SLVERR
        aw_send(32'h10, 8'd0, 2'b11, 4'd6);
        w_send(32'h12345678, 4'hF, 1'b1);
        b_recv(2'b10, 4'd6);
        ar_send(32'h10, 8'd0, 2'b01, 4'd6);
        r_recv(32'hDEADBEEF, 1'b1, 2'b00, 4'd6);

        // WRAP with LEN=2 read: three SLVERR beats of zero
        ar_send(32'h0, 8'd2, 2'b10, 4'd7);
        r_recv(32'd0, 1'b0, 2'b10, 4'd7);
        r_recv(32'd0, 1'b0, 2'b10, 4'd7);
        r_recv(32'd0, 1'b1, 2'b10, 4'd7);

        // Early WLAST in a LEN=3 burst
        aw_send(32'h80, 8'd3, 2'b01, 4'd8);
        w_send(32'h55, 4'hF, 1'b0);
        w_send(32'h66, 4'hF, 1'b1);
        b_recv(2'b10, 4'd8);

        // Address aliasing above the memory depth
        ar_send(32'h1010, 8'd0, 2'b01, 4'd9);
        r_recv(32'hDEADBEEF, 1'b1, 2'b00, 4'd9);

        // Overlapping write and read
        fork
            begin
                aw_send(32'h100, 8'd1, 2'b01, 4'd10);
                w_send(32'h11, 4'hF, 1'b0);
                w_send(32'h22, 4'hF, 1'b1);
                b_recv(2'b00, 4'd10);
            end
            begin
                ar_send(32'h0, 8'd1, 2'b01, 4'd11);
                r_recv(32'd1, 1'b0, 2'b00, 4'd11);
                r_recv(32'h000000FF, 1'b1, 2'b00, 4'd11);
            end
        join
        ar_send(32'h100, 8'd1, 2'b01, 4'd12);
        r_recv(32'h11, 1'b0, 2'b00, 4'd12);
        r_recv(32'h22, 1'b1, 2'b00, 4'd12);

        // Reset in the middle of a read burst
        ar_send(32'h0, 8'd3, 2'b01, 4'd13);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_rvalid", 32'(ifc.S_RVALID), 32'd0);
        chk("midrst_rdata", ifc.S_RDATA, 32'd0);
        chk("midrst_arready", 32'(ifc.S_ARREADY), 32'd0);
        rst = 1'b0;
        #1;
        chk("midrst_arready_rel", 32'(ifc.S_ARREADY), 32'd1);
        chk("midrst_rvalid_rel", 32'(ifc.S_RVALID), 32'd0);
        @(negedge clk);
        ar_send(32'h10, 8'd0, 2'b01, 4'd14);
        r_recv(32'hDEADBEEF, 1'b1, 2'b00, 4'd14);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
